// File: rtl/mem_stage_lsu_pkg.sv
// mem_stage_lsu_pkg: shared LSU state type, RV32I funct3 codes and access legality helpers
package mem_stage_lsu_pkg;
    typedef enum logic [1:0] {IDLE, REQ, DONE} lsu_state_t;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [1:0] RESULTSRC_MEM = 2'b01;
    function automatic logic f3_illegal(input logic [2:0] f3);
        return f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111;
    endfunction
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        return (f3[1:0] == F3_LH[1:0] && a[0]) || (f3[1:0] == F3_LW[1:0] && a != 2'b00);
    endfunction
endpackage

// File: rtl/mem_stage_lsu_if.sv
// mem_stage_lsu_if: req/ack data-memory bus between the LSU (master) and memory (slave)
interface mem_stage_lsu_if #(parameter int XLEN = 32) ();
    logic            bus_req_o;
    logic            bus_we_o;
    logic [XLEN-1:0] bus_addr_o;
    logic [XLEN-1:0] bus_wdata_o;
    logic [3:0]      bus_be_o;
    logic            bus_ack_i;
    logic [XLEN-1:0] bus_rdata_i;
    modport master (output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o,
                    input bus_ack_i, bus_rdata_i);
    modport slave  (input bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o,
                    output bus_ack_i, bus_rdata_i);
endinterface

// File: rtl/mem_stage_lsu_load_align.sv
// mem_stage_lsu_load_align: picks the addressed byte/half of a read word and sign/zero-extends it
module mem_stage_lsu_load_align
    import mem_stage_lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    // lane select by byte offset, then extension by access type
    always_comb begin
        w_byte = i_rdata[{i_off, 3'b000} +: 8];
        w_half = i_rdata[{i_off[1], 4'b0000} +: 16];
        o_data = i_funct3 == F3_LB  ? {{24{w_byte[7]}}, w_byte} :
                 i_funct3 == F3_LBU ? {24'h0, w_byte} :
                 i_funct3 == F3_LH  ? {{16{w_half[15]}}, w_half} :
                 i_funct3 == F3_LHU ? {16'h0, w_half} : i_rdata;
    end
endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM-stage load/store unit turning each access into one req/ack bus transaction
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                memwriteM_i,
    input  logic [1:0]          resultsrcM_i,
    input  logic [2:0]          funct3M_i,
    input  logic [XLEN-1:0]     aluresultM_i,
    input  logic [XLEN-1:0]     writedataM_i,
    mem_stage_lsu_if.master     bus,
    output logic [XLEN-1:0]     readdataM_o,
    output logic                stall_o,
    output logic                fault_o,
    output logic                bus_err_o
);
    lsu_state_t      r_state;
    logic            r_req;
    logic            r_we;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [3:0]      r_be;
    logic [2:0]      r_f3;
    logic [1:0]      r_off;
    logic [7:0]      r_cnt;
    logic [XLEN-1:0] r_rdata;
    logic            r_err;
    logic            w_access;
    logic            w_bad;
    logic            w_idle;
    logic            w_go;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_lane;
    logic [XLEN-1:0] w_ldata;

    mem_stage_lsu_load_align u_align (
        .i_rdata  (bus.bus_rdata_i),
        .i_off    (r_off),
        .i_funct3 (r_f3),
        .o_data   (w_ldata)
    );

    // access decode, stall/fault generation and store lane/byte-enable formation
    always_comb begin
        w_access = memwriteM_i | (resultsrcM_i == RESULTSRC_MEM);
        w_bad    = f3_illegal(funct3M_i) | misaligned(funct3M_i, aluresultM_i[1:0]);
        w_idle   = r_state == IDLE;
        w_go     = w_idle & w_access & ~w_bad;
        fault_o  = w_idle & w_access & w_bad;
        stall_o  = (r_state == REQ) | w_go;
        w_be     = funct3M_i[1:0] == F3_SB[1:0] ? 4'b0001 << aluresultM_i[1:0] :
                   funct3M_i[1:0] == F3_SH[1:0] ? 4'b0011 << aluresultM_i[1:0] : 4'b1111;
        w_lane   = funct3M_i[1:0] == F3_SB[1:0] ? {4{writedataM_i[7:0]}} :
                   funct3M_i[1:0] == F3_SH[1:0] ? {2{writedataM_i[15:0]}} :
                   funct3M_i == F3_SW ? writedataM_i : writedataM_i;
    end

    // IDLE -> REQ -> DONE sequencer with registered bus outputs, timeout and load capture
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= 4'b0000;
            r_f3    <= 3'b000;
            r_off   <= 2'b00;
            r_cnt   <= 8'd0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                IDLE: if (w_go) begin
                    r_state <= REQ;
                    r_req   <= 1'b1;
                    r_we    <= memwriteM_i;
                    r_addr  <= {aluresultM_i[XLEN-1:2], 2'b00};
                    r_wdata <= memwriteM_i ? w_lane : '0;
                    r_be    <= memwriteM_i ? w_be : 4'b1111;
                    r_f3    <= funct3M_i;
                    r_off   <= aluresultM_i[1:0];
                    r_cnt   <= 8'd0;
                end
                REQ: if (bus.bus_ack_i) begin
                    r_state <= DONE;
                    r_req   <= 1'b0;
                    if (!r_we) r_rdata <= w_ldata;
                end else if (r_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
                    r_state <= DONE;
                    r_req   <= 1'b0;
                    r_err   <= 1'b1;
                    if (!r_we) r_rdata <= '0;
                end else begin
                    r_cnt <= r_cnt + 8'd1;
                end
                DONE: r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.bus_req_o   = r_req;
    assign bus.bus_we_o    = r_we;
    assign bus.bus_addr_o  = r_addr;
    assign bus.bus_wdata_o = r_wdata;
    assign bus.bus_be_o    = r_be;
    assign readdataM_o     = r_rdata;
    assign bus_err_o       = r_err;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: directed scoreboard bench for the MEM-stage load/store unit
module tb_mem_stage_lsu;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        memwriteM_i = 1'b0;
    logic [1:0]  resultsrcM_i = 2'b00;
    logic [2:0]  funct3M_i = 3'b000;
    logic [31:0] aluresultM_i = '0;
    logic [31:0] writedataM_i = '0;
    logic [31:0] readdataM_o;
    logic        stall_o;
    logic        fault_o;
    logic        bus_err_o;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_rd = '0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
        logic [31:0] rd;
        int          reqs;
        logic        err;
    } exp_t;
    exp_t sb[$];

    mem_stage_lsu_if bus_if ();

    mem_stage_lsu #(.XLEN(32), .TIMEOUT_CYCLES(4)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .memwriteM_i  (memwriteM_i),
        .resultsrcM_i (resultsrcM_i),
        .funct3M_i    (funct3M_i),
        .aluresultM_i (aluresultM_i),
        .writedataM_i (writedataM_i),
        .bus          (bus_if.master),
        .readdataM_o  (readdataM_o),
        .stall_o      (stall_o),
        .fault_o      (fault_o),
        .bus_err_o    (bus_err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bubble();
        memwriteM_i  = 1'b0;
        resultsrcM_i = 2'b00;
    endtask

    task automatic access(input string tag, input logic we, input logic [1:0] rs, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd, input int ack_wait,
                          input logic [31:0] rdata, input logic [31:0] e_addr, input logic [31:0] e_wdata,
                          input logic [3:0] e_be, input logic [31:0] e_rd, input int e_reqs, input logic e_err);
        exp_t e;
        exp_t o;
        int   reqs;
        logic stuck;
        @(posedge clk_i); #1;
        memwriteM_i  = we;
        resultsrcM_i = rs;
        funct3M_i    = f3;
        aluresultM_i = addr;
        writedataM_i = wd;
        e.addr = e_addr; e.wdata = e_wdata; e.be = e_be; e.we = we;
        e.rd = we ? last_rd : e_rd; e.reqs = e_reqs; e.err = e_err;
        sb.push_back(e);
        last_rd = e.rd;
        #3;
        chk({tag, "/idle_stall"}, 32'(stall_o), 32'd1);
        chk({tag, "/idle_req"}, 32'(bus_if.bus_req_o), 32'd0);
        reqs  = 0;
        stuck = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk_i); #1;
            bus_if.bus_ack_i   = 1'b0;
            bus_if.bus_rdata_i = 32'h5A5A_5A5A;
            if (!bus_if.bus_req_o) begin
                stuck = 1'b0;
                break;
            end
            reqs++;
            if (reqs == 1) begin
                chk({tag, "/addr"}, bus_if.bus_addr_o, sb[0].addr);
                chk({tag, "/we"}, 32'(bus_if.bus_we_o), 32'(sb[0].we));
                chk({tag, "/be"}, 32'(bus_if.bus_be_o), 32'(sb[0].be));
                chk({tag, "/req_stall"}, 32'(stall_o), 32'd1);
                if (sb[0].we) chk({tag, "/wdata"}, bus_if.bus_wdata_o, sb[0].wdata);
            end
            if (reqs > ack_wait) begin
                bus_if.bus_ack_i   = 1'b1;
                bus_if.bus_rdata_i = rdata;
            end
        end
        o = sb.pop_front();
        chk({tag, "/bound"}, 32'(stuck), 32'd0);
        chk({tag, "/req_cycles"}, 32'(reqs), 32'(o.reqs));
        chk({tag, "/done_stall"}, 32'(stall_o), 32'd0);
        chk({tag, "/rdata"}, readdataM_o, o.rd);
        chk({tag, "/err"}, 32'(bus_err_o), 32'(o.err));
        bubble();
        @(posedge clk_i); #1;
        chk({tag, "/err_clear"}, 32'(bus_err_o), 32'd0);
        chk({tag, "/rdata_hold"}, readdataM_o, o.rd);
    endtask

    task automatic fault_case(input string tag, input logic [2:0] f3, input logic [31:0] addr);
        @(posedge clk_i); #1;
        memwriteM_i  = 1'b0;
        resultsrcM_i = 2'b01;
        funct3M_i    = f3;
        aluresultM_i = addr;
        #3;
        chk({tag, "/fault"}, 32'(fault_o), 32'd1);
        chk({tag, "/stall"}, 32'(stall_o), 32'd0);
        @(posedge clk_i); #1;
        chk({tag, "/no_req"}, 32'(bus_if.bus_req_o), 32'd0);
        bubble();
        #1;
        chk({tag, "/fault_clear"}, 32'(fault_o), 32'd0);
    endtask

    initial begin
        bus_if.bus_ack_i   = 1'b0;
        bus_if.bus_rdata_i = '0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst/req", 32'(bus_if.bus_req_o), 32'd0);
        chk("rst/be", 32'(bus_if.bus_be_o), 32'd0);
        chk("rst/rdata", readdataM_o, 32'd0);
        chk("rst/stall", 32'(stall_o), 32'd0);
        chk("rst/err", 32'(bus_err_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;

        access("lw",  1'b0, 2'b01, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF, 32'h100, 32'h0, 4'hF, 32'hDEADBEEF, 1, 1'b0);
        access("sb",  1'b1, 2'b00, 3'b000, 32'h203, 32'hA5, 1, 32'h0, 32'h200, 32'hA5A5A5A5, 4'b1000, 32'h0, 2, 1'b0);
        access("lb",  1'b0, 2'b01, 3'b000, 32'h1, 32'h0, 0, 32'h00008000, 32'h0, 32'h0, 4'hF, 32'hFFFFFF80, 1, 1'b0);
        access("lbu", 1'b0, 2'b01, 3'b100, 32'h1, 32'h0, 0, 32'h00008000, 32'h0, 32'h0, 4'hF, 32'h00000080, 1, 1'b0);
        access("lh",  1'b0, 2'b01, 3'b001, 32'h6, 32'h0, 2, 32'h80010000, 32'h4, 32'h0, 4'hF, 32'hFFFF8001, 3, 1'b0);
        access("lhu", 1'b0, 2'b01, 3'b101, 32'h6, 32'h0, 0, 32'h80010000, 32'h4, 32'h0, 4'hF, 32'h00008001, 1, 1'b0);
        access("sh",  1'b1, 2'b00, 3'b001, 32'h202, 32'h00001234, 0, 32'h0, 32'h200, 32'h12341234, 4'b1100, 32'h0, 1, 1'b0);
        access("sw_both", 1'b1, 2'b01, 3'b010, 32'h10, 32'hCAFEF00D, 0, 32'h0, 32'h10, 32'hCAFEF00D, 4'hF, 32'h0, 1, 1'b0);

        fault_case("lw_mis", 3'b010, 32'h102);
        fault_case("f3_011", 3'b011, 32'h100);

        access("sw_to", 1'b1, 2'b00, 3'b010, 32'h20, 32'h1, 1000, 32'h0, 32'h20, 32'h1, 4'hF, 32'h0, 4, 1'b1);
        access("lw_to", 1'b0, 2'b01, 3'b010, 32'h24, 32'h0, 1000, 32'h0, 32'h24, 32'h0, 4'hF, 32'h0, 4, 1'b1);
        access("lw2", 1'b0, 2'b01, 3'b010, 32'h28, 32'h0, 0, 32'h01020304, 32'h28, 32'h0, 4'hF, 32'h01020304, 1, 1'b0);

        @(posedge clk_i); #1;
        bus_if.bus_ack_i   = 1'b1;
        bus_if.bus_rdata_i = 32'hFFFFFFFF;
        repeat (2) @(posedge clk_i);
        #1;
        chk("stray_ack/req", 32'(bus_if.bus_req_o), 32'd0);
        chk("stray_ack/rdata", readdataM_o, last_rd);
        bus_if.bus_ack_i = 1'b0;

        @(posedge clk_i); #1;
        memwriteM_i  = 1'b1;
        funct3M_i    = 3'b010;
        aluresultM_i = 32'h40;
        writedataM_i = 32'h11;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_mid/req_before", 32'(bus_if.bus_req_o), 32'd1);
        #2;
        rst_i = 1'b0;
        bubble();
        #1;
        chk("rst_mid/req", 32'(bus_if.bus_req_o), 32'd0);
        chk("rst_mid/addr", bus_if.bus_addr_o, 32'h0);
        chk("rst_mid/rdata", readdataM_o, 32'h0);
        chk("rst_mid/stall", 32'(stall_o), 32'd0);
        last_rd = '0;
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        access("lw_post_rst", 1'b0, 2'b01, 3'b010, 32'h300, 32'h0, 0, 32'h13579BDF, 32'h300, 32'h0, 4'hF, 32'h13579BDF, 1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
